// File: rtl/dma_init_sequencer.sv
// rtl/dma_init_sequencer.sv - issues masked one-hot DMA init tasks in order with per-task timeout and deferred abort
module dma_init_sequencer #(
    parameter int DMA_INIT_TASK_CNT = 8,
    parameter int TASK_IDX_WIDTH    = 3,
    parameter int TIMEOUT_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES    = 16'hFFFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DMA_INIT_TASK_CNT-1:0] task_mask,
    input  logic                         abort,
    output logic [DMA_INIT_TASK_CNT-1:0] slaveInit,
    input  logic [DMA_INIT_TASK_CNT-1:0] slaveFinInit,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic                         error,
    output logic [TASK_IDX_WIDTH-1:0]    err_task_idx,
    output logic [TASK_IDX_WIDTH:0]      tasks_done
);

    localparam int N  = DMA_INIT_TASK_CNT;
    localparam int IW = TASK_IDX_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ABORT,
        S_ERR
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [N-1:0]             mask_q;
    logic [IW-1:0]            idx_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic                     abort_q;
    logic                     found;
    logic [IW-1:0]            found_idx;
    logic                     fin_hit;
    logic                     tmo_hit;

    // idx_q is one bit wider than a task index so it can step past the last task
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_q[i] && (IW'(i) >= idx_q)) begin
                found     = 1'b1;
                found_idx = IW'(i);
            end
        end
    end

    assign fin_hit = (slaveFinInit == slaveInit);
    assign tmo_hit = (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // GAP also performs the scan so the zero cycle between requests is exactly one
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN, S_GAP: begin
                if (!found) begin
                    state_d = S_DONE;
                end else if (abort_q || abort) begin
                    state_d = S_ABORT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (fin_hit) begin
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ABORT, S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q       <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            abort_q      <= 1'b0;
            slaveInit    <= '0;
            error        <= 1'b0;
            err_task_idx <= '0;
            tasks_done   <= '0;
        end else begin
            if ((state_q != S_IDLE) && abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q       <= task_mask;
                        idx_q        <= '0;
                        abort_q      <= 1'b0;
                        error        <= 1'b0;
                        err_task_idx <= '0;
                        tasks_done   <= '0;
                    end
                end
                S_SCAN, S_GAP: begin
                    if (state_d == S_ISSUE) begin
                        idx_q     <= found_idx;
                        slaveInit <= N'(1) << found_idx;
                    end
                end
                S_ISSUE: begin
                    tmo_q <= '0;
                end
                S_WAIT: begin
                    if (fin_hit) begin
                        tasks_done <= tasks_done + IW'(1);
                        idx_q      <= idx_q + IW'(1);
                        slaveInit  <= '0;
                    end else if (tmo_hit) begin
                        error        <= 1'b1;
                        err_task_idx <= idx_q[TASK_IDX_WIDTH-1:0];
                        slaveInit    <= '0;
                    end else begin
                        tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                    slaveInit <= '0;
                end
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign aborted = (state_q == S_ABORT);

endmodule

// File: tb/tb_dma_init_sequencer.sv
// tb/tb_dma_init_sequencer.sv - table, random and hand-sequence checks for dma_init_sequencer
module tb_dma_init_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] task_mask;
    logic       abort;
    logic [7:0] slaveInit;
    logic [7:0] slaveFinInit;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       error;
    logic [2:0] err_task_idx;
    logic [3:0] tasks_done;

    always #5 clk = ~clk;

    dma_init_sequencer #(
        .DMA_INIT_TASK_CNT(8),
        .TASK_IDX_WIDTH   (3),
        .TIMEOUT_WIDTH    (16),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .task_mask   (task_mask),
        .abort       (abort),
        .slaveInit   (slaveInit),
        .slaveFinInit(slaveFinInit),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .error       (error),
        .err_task_idx(err_task_idx),
        .tasks_done  (tasks_done)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] hang_mask   = 8'h00;
    int         ack_delay   = 3;
    int         abort_task  = -1;
    logic       abort_force = 1'b0;

    typedef struct {
        logic [63:0] seq;
        int          nreq;
        int          done_cnt;
        int          abort_cnt;
        int          first_cyc;
        int          done_cyc;
        int          busy_cyc;
        bit          onehot_bad;
        bit          gap_bad;
        bit          timed_out;
        logic        err;
        logic [2:0]  eidx;
        logic [3:0]  tdone;
        logic [7:0]  final_si;
    } obs_t;

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  hang;
        int          dly;
        int          abt;
        bit          aws;
        bit          poke;
        logic [63:0] exp_seq;
        int          exp_nreq;
        int          exp_first;
        int          exp_done;
        int          exp_ab;
        logic        exp_err;
        int          exp_eidx;
        int          exp_tdone;
        int          exp_busy;
    } vec_t;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // writer model: acks ack_delay cycles after a new request, never acks hung tasks
    initial begin
        logic [7:0] last_req;
        int         wait_cnt;
        last_req     = 8'h00;
        wait_cnt     = 0;
        slaveFinInit = 8'h00;
        abort        = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            slaveFinInit = 8'h00;
            abort        = abort_force;
            if (slaveInit != 8'h00) begin
                if (slaveInit != last_req) begin
                    last_req = slaveInit;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
                if (wait_cnt == ack_delay && (slaveInit & hang_mask) == 8'h00) slaveFinInit = slaveInit;
                if (abort_task >= 0 && slaveInit == (8'd1 << abort_task) && wait_cnt == 1) abort = 1'b1;
            end else begin
                last_req = 8'h00;
            end
        end
    end

    task automatic run_seq(input logic [7:0] m, input logic [7:0] hm, input int dly, input int abt,
                           input bit aws, input bit poke, output obs_t o);
        logic [7:0] v;
        logic [7:0] prev;
        int         zero_run;
        int         cyc;
        o          = '{default: 0};
        hang_mask  = hm;
        ack_delay  = dly;
        abort_task = abt;
        @(negedge clk);
        task_mask   = m;
        start       = 1'b1;
        abort_force = aws;
        @(negedge clk);
        start       = 1'b0;
        abort_force = 1'b0;
        task_mask   = 8'($urandom);
        prev        = 8'h00;
        zero_run    = 0;
        cyc         = 1;
        while (1) begin
            v = slaveInit;
            if (busy) o.busy_cyc++;
            if (done) begin
                o.done_cnt++;
                o.done_cyc = cyc;
            end
            if (aborted) o.abort_cnt++;
            if (v != 8'h00) begin
                if ($countones(v) != 1) o.onehot_bad = 1'b1;
                if (v != prev) begin
                    if (o.nreq > 0 && zero_run != 1) o.gap_bad = 1'b1;
                    if (o.nreq == 0) o.first_cyc = cyc;
                    if (o.nreq < 8) o.seq[o.nreq*8 +: 8] = v;
                    o.nreq++;
                end
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev = v;
            if (!busy) break;
            if (cyc > 1500) begin
                o.timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 4) begin
                start     = 1'b1;
                task_mask = 8'h00;
            end
        end
        start      = 1'b0;
        o.err      = error;
        o.eidx     = err_task_idx;
        o.tdone    = tasks_done;
        o.final_si = slaveInit;
    endtask

    task automatic check_obs(input string nm, input obs_t o, input logic [63:0] eseq, input int enreq,
                             input int edone, input int eab, input logic eerr, input int eeidx, input int etd);
        check({nm, "_timeout"}, o.timed_out, 0);
        check({nm, "_seq"}, o.seq, eseq);
        check({nm, "_nreq"}, o.nreq, enreq);
        check({nm, "_done"}, o.done_cnt, edone);
        check({nm, "_aborted"}, o.abort_cnt, eab);
        check({nm, "_error"}, o.err, eerr);
        check({nm, "_err_idx"}, o.eidx, eeidx);
        check({nm, "_tasks_done"}, o.tdone, etd);
        check({nm, "_final_si"}, o.final_si, 0);
        check({nm, "_onehot"}, o.onehot_bad, 0);
        check({nm, "_gap"}, o.gap_bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[9];
        obs_t       o;
        logic [7:0] q[$];
        logic [63:0] eseq;
        logic [7:0] m;
        logic [7:0] hm;
        int         abt;
        int         etd;
        int         eidx;
        int         ed;
        int         ea;
        logic       eerr;
        bit         stop;
        bit         reached;

        vt[0] = '{8'hFF, 8'h00, 3, -1, 1'b0, 1'b0, 64'h8040201008040201, 8, 2, 1, 0, 1'b0, 0, 8, -1};
        vt[1] = '{8'hA5, 8'h00, 2, -1, 1'b0, 1'b0, 64'h0000000080200401, 4, 2, 1, 0, 1'b0, 0, 4, -1};
        vt[2] = '{8'h00, 8'h00, 1, -1, 1'b0, 1'b0, 64'h0, 0, 0, 1, 0, 1'b0, 0, 0, 2};
        vt[3] = '{8'hFF, 8'h08, 2, -1, 1'b0, 1'b0, 64'h0000000008040201, 4, 2, 0, 0, 1'b1, 3, 3, -1};
        vt[4] = '{8'hFF, 8'h00, 3, 2, 1'b0, 1'b0, 64'h0000000000040201, 3, 2, 0, 1, 1'b0, 0, 3, -1};
        vt[5] = '{8'hFF, 8'h00, 1, -1, 1'b1, 1'b1, 64'h8040201008040201, 8, 2, 1, 0, 1'b0, 0, 8, -1};
        vt[6] = '{8'h80, 8'h00, 2, -1, 1'b0, 1'b0, 64'h80, 1, -1, 1, 0, 1'b0, 0, 1, -1};
        vt[7] = '{8'h40, 8'h00, 1, 6, 1'b0, 1'b0, 64'h40, 1, -1, 1, 0, 1'b0, 0, 1, -1};
        vt[8] = '{8'h03, 8'h01, 2, -1, 1'b0, 1'b0, 64'h01, 1, 2, 0, 0, 1'b1, 0, 0, -1};

        reset     = 1'b0;
        start     = 1'b0;
        task_mask = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_slaveInit", slaveInit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_error", error, 0);
        check("rst_err_idx", err_task_idx, 0);
        check("rst_tasks_done", tasks_done, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_seq(vt[i].mask, vt[i].hang, vt[i].dly, vt[i].abt, vt[i].aws, vt[i].poke, o);
            check_obs($sformatf("vec%0d", i), o, vt[i].exp_seq, vt[i].exp_nreq, vt[i].exp_done,
                      vt[i].exp_ab, vt[i].exp_err, vt[i].exp_eidx, vt[i].exp_tdone);
            if (vt[i].exp_first >= 0) check($sformatf("vec%0d_first_cyc", i), o.first_cyc, vt[i].exp_first);
            if (vt[i].exp_busy >= 0) begin
                check($sformatf("vec%0d_busy_cyc", i), o.busy_cyc, vt[i].exp_busy);
                check($sformatf("vec%0d_done_cyc", i), o.done_cyc, vt[i].exp_busy);
            end
        end

        // reset in the middle of task 5, then a clean restart
        hang_mask  = 8'h00;
        ack_delay  = 6;
        abort_task = -1;
        @(negedge clk);
        task_mask = 8'hFF;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (slaveInit == 8'h20) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid_reach_task5", reached, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_slaveInit", slaveInit, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tasks_done", tasks_done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_seq(8'hFF, 8'h00, 3, -1, 1'b0, 1'b0, o);
        check_obs("after_rst", o, 64'h8040201008040201, 8, 1, 0, 1'b0, 0, 8);
        check("after_rst_first_cyc", o.first_cyc, 2);

        // random masks, hangs and aborts against a task-list model
        for (int r = 0; r < 30; r++) begin
            m   = 8'($urandom);
            hm  = 8'h00;
            abt = -1;
            if ($urandom_range(0, 2) == 0) hm = 8'd1 << $urandom_range(0, 7);
            else if ($urandom_range(0, 1) == 0 && m != 8'h00) begin
                abt = $urandom_range(0, 7);
                while (!m[abt]) abt = $urandom_range(0, 7);
            end
            q.delete();
            etd  = 0;
            eidx = 0;
            eerr = 1'b0;
            ed   = 0;
            ea   = 0;
            stop = 1'b0;
            for (int b = 0; b < 8; b++) begin
                if (!stop && m[b]) begin
                    q.push_back(8'd1 << b);
                    if (hm[b]) begin
                        eerr = 1'b1;
                        eidx = b;
                        stop = 1'b1;
                    end else begin
                        etd++;
                        if (b == abt) begin
                            if ((m >> (b + 1)) != 8'h00) ea = 1;
                            else ed = 1;
                            stop = 1'b1;
                        end
                    end
                end
            end
            if (!stop) ed = 1;
            eseq = 64'h0;
            for (int j = 0; j < q.size(); j++) eseq[j*8 +: 8] = q[j];
            run_seq(m, hm, $urandom_range(1, 8), abt, 1'b0, 1'b0, o);
            check_obs($sformatf("rnd%0d_m%02h_h%02h_a%0d", r, m, hm, abt), o, eseq, q.size(), ed, ea,
                      eerr, eidx, etd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
